// File: rtl/soc_io_master_if.sv
// Signal bundle between the CPU load/store path, soc_io_master and the
// simple IO register bus (per-slave select, write-enable and ready).
interface soc_io_master_if #(
   parameter int IO_MAP_WIDTH = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int NUM_SLAVES   = 4
);
   logic                               cpu_req;
   logic                               cpu_we;
   logic [ADDR_WIDTH-1:0]              cpu_addr;
   logic [IO_MAP_WIDTH-1:0]            cpu_wdata;
   logic                               cpu_busy;
   logic                               cpu_done;
   logic                               cpu_err;
   logic [IO_MAP_WIDTH-1:0]            cpu_rdata;
   logic [NUM_SLAVES-1:0]              io_sel;
   logic [NUM_SLAVES-1:0]              io_we;
   logic [3:0]                         io_addr;
   logic [IO_MAP_WIDTH-1:0]            io_wdata;
   logic [NUM_SLAVES*IO_MAP_WIDTH-1:0] io_rdata;
   logic [NUM_SLAVES-1:0]              io_ready;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  io_rdata, io_ready,
      output cpu_busy, cpu_done, cpu_err, cpu_rdata,
      output io_sel, io_we, io_addr, io_wdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output io_rdata, io_ready,
      input  cpu_busy, cpu_done, cpu_err, cpu_rdata,
      input  io_sel, io_we, io_addr, io_wdata
   );
endinterface

// File: rtl/soc_io_master.sv
// Memory-mapped IO initiator: decodes CPU accesses onto the IO register
// bus, waits for the selected slave's ready with a timeout, and responds.
module soc_io_master #(
   parameter int                    IO_MAP_WIDTH = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE      = 32'h1000_0000,
   parameter int                    NUM_SLAVES   = 4,
   parameter int                    TIMEOUT      = 16
) (
   input  logic             clk,
   input  logic             rst,
   soc_io_master_if.master  bus
);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_SLAVES-1:0]   sel_q, sel_d;
   logic [NUM_SLAVES-1:0]   iowe_q, iowe_d;
   logic [3:0]              ioaddr_q, ioaddr_d;
   logic [IO_MAP_WIDTH-1:0] iowdata_q, iowdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [IO_MAP_WIDTH-1:0] rdata_q, rdata_d;

   logic                    win_hit;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    rdy_sel;
   logic [IO_MAP_WIDTH-1:0] rd_sel;

   assign win_hit =
      bus.cpu_addr[ADDR_WIDTH-1:12] == IO_BASE[ADDR_WIDTH-1:12];

   // Out-of-range indices leave dec_sel empty, which doubles as decode fail
   always_comb begin
      dec_sel = '0;
      rdy_sel = 1'b0;
      rd_sel  = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (bus.cpu_addr[11:8] == 4'(k))
            dec_sel[k] = 1'b1;
         if (sel_q[k]) begin
            rdy_sel = rdy_sel | bus.io_ready[k];
            rd_sel  = rd_sel |
               bus.io_rdata[k*IO_MAP_WIDTH +: IO_MAP_WIDTH];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      iowe_d    = iowe_q;
      ioaddr_d  = ioaddr_q;
      iowdata_d = iowdata_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               busy_d  = 1'b1;
               cnt_d   = '0;
               rdata_d = '0;
               if (win_hit && |dec_sel) begin
                  sel_d     = dec_sel;
                  iowe_d    = bus.cpu_we ? dec_sel : '0;
                  ioaddr_d  = bus.cpu_addr[3:0];
                  iowdata_d = bus.cpu_wdata;
                  err_d     = 1'b0;
                  state_d   = ACCESS;
               end else begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            // Ready wins over a timeout landing on the same edge
            if (rdy_sel || cnt_q == CW'(TIMEOUT-1)) begin
               rdata_d   = (rdy_sel && ~|iowe_q) ? rd_sel : '0;
               err_d     = ~rdy_sel;
               done_d    = 1'b1;
               sel_d     = '0;
               iowe_d    = '0;
               ioaddr_d  = '0;
               iowdata_d = '0;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_q     <= '0;
         iowe_q    <= '0;
         ioaddr_q  <= '0;
         iowdata_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         iowe_q    <= iowe_d;
         ioaddr_q  <= ioaddr_d;
         iowdata_q <= iowdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.cpu_busy  = busy_q;
   assign bus.cpu_done  = done_q;
   assign bus.cpu_err   = err_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.io_sel    = sel_q;
   assign bus.io_we     = iowe_q;
   assign bus.io_addr   = ioaddr_q;
   assign bus.io_wdata  = iowdata_q;
endmodule

// File: tb/tb_soc_io_master.sv
// Bench for soc_io_master: behavioural slaves plus a transaction-level
// reference model of latency, error and read data.
module tb_soc_io_master;
   localparam int W  = 32;
   localparam int NS = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   soc_io_master_if #(
      .IO_MAP_WIDTH(W), .ADDR_WIDTH(32), .NUM_SLAVES(NS)
   ) bus ();

   soc_io_master #(
      .IO_MAP_WIDTH(W), .ADDR_WIDTH(32), .IO_BASE(32'h1000_0000),
      .NUM_SLAVES(NS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // slave environment: offsets 0..11 mapped, 12..15 never answer;
   // slave 1 offset 8 is the read-only gpio_in port
   logic [W-1:0]         slv_mem [NS][16];
   logic [NS-1:0][W-1:0] slv_rd;
   logic [NS-1:0]        slv_rdy;
   logic [NS-1:0]        stray = '0;
   logic [W-1:0]         gpio_in = '0;
   int                   dly  [NS];
   int                   wcnt [NS];

   assign bus.io_rdata = slv_rd;
   assign bus.io_ready = slv_rdy | stray;

   function automatic logic [W-1:0] pat(int k, int o);
      return 32'hC0DE_0000 | 32'(k << 8) | 32'(o);
   endfunction

   function automatic bit is_gpio_in(int k, int o);
      return k == 1 && o == 8;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         slv_rdy <= '0;
         slv_rd  <= '0;
         for (int k = 0; k < NS; k++) begin
            wcnt[k] <= 0;
            for (int o = 0; o < 16; o++) slv_mem[k][o] <= pat(k, o);
         end
      end else begin
         for (int k = 0; k < NS; k++) begin
            if (slv_rdy[k]) begin
               slv_rdy[k] <= 1'b0;
            end else if (bus.io_sel[k] && bus.io_addr < 4'd12) begin
               if (wcnt[k] >= dly[k]) begin
                  slv_rdy[k] <= 1'b1;
                  wcnt[k]    <= 0;
                  slv_rd[k]  <= is_gpio_in(k, int'(bus.io_addr)) ?
                                gpio_in : slv_mem[k][bus.io_addr];
                  if (bus.io_we[k] && !is_gpio_in(k, int'(bus.io_addr)))
                     slv_mem[k][bus.io_addr] <= bus.io_wdata;
               end else begin
                  wcnt[k] <= wcnt[k] + 1;
               end
            end else begin
               wcnt[k] <= 0;
            end
         end
      end
   end

   // reference model: register contents as seen by the CPU
   logic [W-1:0] mdl_mem [NS][16];

   function automatic void mdl_init();
      for (int k = 0; k < NS; k++)
         for (int o = 0; o < 16; o++) mdl_mem[k][o] = pat(k, o);
   endfunction

   task automatic wait_idle(input string nm);
      int c;
      c = 0;
      while (bus.cpu_busy !== 1'b0 && c < 40) begin
         @(negedge clk);
         c++;
      end
      if (bus.cpu_busy !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s idle_wait: busy=%b after %0d cycles", nm,
                  bus.cpu_busy, c);
      end
   endtask

   task automatic run_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int stray_at,
                          input string nm);
      bit            ok, mapped, seen, exp_err;
      int            idx, off, lat, n, selc;
      logic [W-1:0]  exp_rd;
      logic [NS-1:0] esel, one;
      idx    = int'(addr[11:8]);
      off    = int'(addr[3:0]);
      ok     = addr[31:12] == 20'h10000 && idx < NS;
      mapped = off < 12;
      one    = 1;
      esel   = ok ? one << idx : '0;
      if (!ok) begin
         lat = 0; exp_err = 1; exp_rd = '0;
      end else if (!mapped || 2 + dly[idx] > TO) begin
         lat = TO; exp_err = 1; exp_rd = '0;
      end else begin
         lat = 2 + dly[idx];
         exp_err = 0;
         if (we) begin
            exp_rd = '0;
            if (!is_gpio_in(idx, off)) mdl_mem[idx][off] = wd;
         end else begin
            exp_rd = is_gpio_in(idx, off) ? gpio_in : mdl_mem[idx][off];
         end
      end
      wait_idle(nm);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
      @(negedge clk);
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = $urandom;
      bus.cpu_wdata = $urandom;
      checks++;
      if (bus.cpu_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_on_accept: got %b expected 1", nm,
                  bus.cpu_busy);
      end
      n = 0; selc = 0; seen = 0;
      while (n <= TO + 4) begin
         stray = (n == stray_at) ? 4'b0100 : 4'b0000;
         if (bus.cpu_done === 1'b1) begin
            seen = 1;
            break;
         end
         if (bus.io_sel !== '0) selc++;
         checks++;
         if (bus.io_sel !== esel || bus.io_we !== (we ? esel : 4'b0000) ||
             bus.io_addr !== addr[3:0] || bus.io_wdata !== wd) begin
            errors++;
            $display("FAIL %s bus_drive: sel=%b we=%b addr=%h wd=%h expected sel=%b we=%b addr=%h wd=%h",
                     nm, bus.io_sel, bus.io_we, bus.io_addr, bus.io_wdata,
                     esel, we ? esel : 4'b0000, addr[3:0], wd);
         end
         @(negedge clk);
         n++;
      end
      stray = '0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_wait: no cpu_done within %0d cycles", nm, n);
      end
      checks++;
      if (n != lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", nm, n, lat);
      end
      checks++;
      if (selc != (ok ? lat : 0)) begin
         errors++;
         $display("FAIL %s sel_cycles: got %0d expected %0d", nm, selc,
                  ok ? lat : 0);
      end
      checks++;
      if (bus.cpu_err !== exp_err || bus.cpu_rdata !== exp_rd) begin
         errors++;
         $display("FAIL %s response: err=%b rdata=%h expected err=%b rdata=%h",
                  nm, bus.cpu_err, bus.cpu_rdata, exp_err, exp_rd);
      end
      checks++;
      if (bus.io_sel !== '0 || bus.io_we !== '0 || bus.io_addr !== '0 ||
          bus.io_wdata !== '0) begin
         errors++;
         $display("FAIL %s bus_release: sel=%b we=%b addr=%h wd=%h expected all 0",
                  nm, bus.io_sel, bus.io_we, bus.io_addr, bus.io_wdata);
      end
      @(negedge clk);
      checks++;
      if (bus.cpu_done !== 1'b0 || bus.cpu_busy !== 1'b0 ||
          bus.cpu_rdata !== exp_rd) begin
         errors++;
         $display("FAIL %s after_done: done=%b busy=%b rdata=%h expected 0 0 %h",
                  nm, bus.cpu_done, bus.cpu_busy, bus.cpu_rdata, exp_rd);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      for (int k = 0; k < NS; k++) dly[k] = 0;
      mdl_init();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0 ||
          bus.cpu_err !== 1'b0 || bus.cpu_rdata !== '0) begin
         errors++;
         $display("FAIL reset_cpu: busy=%b done=%b err=%b rdata=%h expected all 0",
                  bus.cpu_busy, bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
      end
      checks++;
      if (bus.io_sel !== '0 || bus.io_we !== '0 || bus.io_addr !== '0 ||
          bus.io_wdata !== '0) begin
         errors++;
         $display("FAIL reset_io: sel=%b we=%b addr=%h wd=%h expected all 0",
                  bus.io_sel, bus.io_we, bus.io_addr, bus.io_wdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      for (int k = 0; k < NS; k++) dly[k] = 0;
      run_txn(1'b1, 32'h1000_0104, 32'h0000_00A5, -1, "write_gpio");
      checks++;
      if (slv_mem[1][4] !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL write_gpio gpio_out: got %h expected 000000a5",
                  slv_mem[1][4]);
      end
   endtask

   task automatic test_read();
      logic [W-1:0] held;
      gpio_in = 32'h1234_5678;
      run_txn(1'b0, 32'h1000_0108, $urandom, -1, "read_gpio");
      held = 32'h1234_5678;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.cpu_rdata !== held) begin
            errors++;
            $display("FAIL read_hold: rdata=%h expected %h", bus.cpu_rdata,
                     held);
         end
      end
   endtask

   task automatic test_decode_err();
      run_txn(1'b0, 32'h2000_0000, $urandom, -1, "decode_window");
      run_txn(1'b1, 32'h1000_0500, $urandom, -1, "decode_index");
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 32'h1000_010C, '0, 5, "timeout_stray");
   endtask

   task automatic test_busy_ignore();
      int           acc [$];
      int           step, exp_n;
      bit           prev_busy;
      logic [31:0]  a, d;
      dly[0] = int'($urandom_range(0, 2));
      step   = dly[0] + 4;
      wait_idle("busy_ignore");
      prev_busy = 1'b0;
      for (int c = 0; c < 14; c++) begin
         bus.cpu_req = 1'b1;
         bus.cpu_we  = 1'b1;
         d = $urandom;
         if (bus.cpu_busy === 1'b0) begin
            a = 32'h1000_0000 | 32'($urandom_range(0, 11));
            mdl_mem[0][a[3:0]] = d;
         end else begin
            a = 32'h1000_0300;
         end
         bus.cpu_addr  = a;
         bus.cpu_wdata = d;
         @(negedge clk);
         if (bus.cpu_busy === 1'b1 && !prev_busy) acc.push_back(c);
         prev_busy = bus.cpu_busy;
         checks++;
         if (bus.io_sel[3] !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore sel3: io_sel=%b expected bit3 0",
                     bus.io_sel);
         end
      end
      bus.cpu_req = 1'b0;
      wait_idle("busy_ignore");
      exp_n = (13 / step) + 1;
      checks++;
      if (acc.size() != exp_n) begin
         errors++;
         $display("FAIL busy_ignore accepts: got %0d expected %0d",
                  acc.size(), exp_n);
      end
      foreach (acc[i]) begin
         checks++;
         if (acc[i] != i * step) begin
            errors++;
            $display("FAIL busy_ignore spacing: accept %0d at cycle %0d expected %0d",
                     i, acc[i], i * step);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < NS; k++) dly[k] = 0;
      wait_idle("reset_mid");
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 32'h1000_000C;
      bus.cpu_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.io_sel !== 4'b0001 || bus.io_we !== 4'b0001) begin
         errors++;
         $display("FAIL reset_mid pre: sel=%b we=%b expected 0001 0001",
                  bus.io_sel, bus.io_we);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.io_sel !== '0 || bus.io_we !== '0 || bus.cpu_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: sel=%b we=%b busy=%b expected 0 0 0",
                  bus.io_sel, bus.io_we, bus.cpu_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      mdl_init();
      @(negedge clk);
      run_txn(1'b0, 32'h1000_0203, $urandom, -1, "post_reset_read");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < NS; k++) dly[k] = int'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0)
            a = $urandom;
         else
            a = 32'h1000_0000 | 32'($urandom_range(0, 4) << 8) |
                32'($urandom_range(0, 15));
         run_txn(1'($urandom), a, $urandom, -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_decode_err();
      test_timeout();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
